alu_multiciclo: RTL and testbench
=================================

Name: alu_multiciclo

Overview:
- Datapath ALU that sits directly downstream of the ALU control decoder and consumes its 4-bit `sel` code.
- Executes add, sub, mul, div, and, or, xor, not and slt on two WIDTH-bit operands.
- Logic ops and add/sub complete in one cycle; mul and div are iterative multi-cycle engines behind a start/busy/done handshake.
- The result is registered and held for the writeback stage.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sel  input  4  operation code from the ALU control decoder:
  - 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and
  - 0101 or, 0110 xor, 0111 not, 1000 slt
- a  input  WIDTH  operand A, captured at accepted start.
- b  input  WIDTH  operand B, captured at accepted start.
- busy  output  1  high while an operation is in flight, including the DONE cycle.
- done  output  1  single-cycle pulse when result becomes valid.
- result  output  WIDTH  registered result, held until the next accepted start completes.
- zero  output  1  high when result == 0, registered with result.
- div_by_zero  output  1  high when the last op was div with b == 0; held with result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - busy=0, done=0, result=0, zero=1, div_by_zero=0.
  - Internal operand, accumulator and counter registers cleared.
  - Reset asserted mid-operation aborts it; no done is produced.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1: a, b and sel are latched (later changes to the inputs are ignored).
  - sel in {0000,0001,0100,0101,0110,0111,1000} or undefined: compute, go to DONE.
  - sel=0010: go to MUL.
  - sel=0011 with b!=0: go to DIV.
  - sel=0011 with b==0: go to DONE.
- Single-cycle op results:
  - add: a+b mod 2^WIDTH.
  - sub: a-b mod 2^WIDTH.
  - and/or/xor: bitwise.
  - not: ~a (b ignored).
  - slt: 1 if signed(a) < signed(b), else 0, zero-extended.
  - Undefined sel (1001-1111): result=0.
- MUL: unsigned shift-add, one multiplier bit per cycle for exactly WIDTH cycles, then DONE.
  - result = low WIDTH bits of a*b.
- DIV: unsigned restoring division, one quotient bit per cycle for exactly WIDTH cycles, then DONE.
  - result = floor(a/b).
- Divide by zero: no iteration; result = all ones, div_by_zero=1, done one cycle after start.
- DONE: done=1 for exactly one cycle; next state IDLE. result, zero and div_by_zero are updated on entry to DONE.
- Latency, with the start sample at cycle edge N:
  - single-cycle ops and div-by-zero: done high in cycle N+1.
  - mul and div: done high in cycle N+WIDTH+1.
- busy rises in the cycle after start is accepted and falls when state returns to IDLE.
- start while busy=1 is ignored (not queued).
- start in the same cycle that DONE is exiting is not accepted; it must be held or re-asserted while in IDLE.
- div_by_zero clears on the next accepted start.
- No X is ever driven on result.

Optional Feature:
- Macro: ALU_MUL_FAST_EN.
- Defined:
  - mul uses a single-cycle combinational multiplier and follows the single-cycle path (done at N+1).
  - The MUL state and shift-add engine are not built.
- Undefined: iterative WIDTH-cycle multiplier as described above.
- All other ops are identical in both builds.

Test Plan (WIDTH=32):
- Reset, then add: a=0x7FFFFFFF, b=1, sel=0000 -> at N+1 done=1, result=0x80000000, zero=0. Then sub a=5, b=5 -> result=0, zero=1.
- slt signed: a=0xFFFFFFFF (-1), b=1 -> result=1. Swapped operands -> result=0. not a=0x0F0F0F0F -> result=0xF0F0F0F0.
- mul: a=0x00012345, b=0x00000100 -> busy for 33 cycles, done at N+33, result=0x01234500 (N+1 with ALU_MUL_FAST_EN). Also a=0xFFFFFFFF, b=2 -> result=0xFFFFFFFE.
- div: a=100, b=7 -> done at N+33, result=14, div_by_zero=0. Then a=9, b=0 -> done at N+1, result=0xFFFFFFFF, div_by_zero=1.
- Handshake: during a div, pulse start with sel=0000 and change a/b -> ignored. Final result uses the latched operands; exactly one done pulse.
- Reset mid-op: assert rst_n=0 at cycle 10 of a mul -> busy=0, done=0, result=0 immediately (asynchronous). After release, a new add completes normally.

Source files
------------

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle add/sub/logic/slt, iterative shift-add mul and restoring div.
// Optional build macro ALU_MUL_FAST_EN replaces the iterative multiplier with a combinational one.
module alu_multiciclo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;

`ifdef ALU_MUL_FAST_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`endif

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic [WIDTH-1:0]  quick_res;
    logic [WIDTH:0]    rem_shift;
    logic [WIDTH:0]    rem_diff;
    logic [WIDTH-1:0]  div_rem;
    logic [WIDTH-1:0]  div_quo;
`ifndef ALU_MUL_FAST_EN
    logic [WIDTH-1:0]  mul_sum;
`endif

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Results for every op that finishes straight out of IDLE, taken from the live inputs.
    always_comb begin
        quick_res = '0;
        case (sel)
            OP_ADD:  quick_res = a + b;
            OP_SUB:  quick_res = a - b;
`ifdef ALU_MUL_FAST_EN
            OP_MUL:  quick_res = a * b;
`endif
            OP_DIV:  quick_res = '1;
            OP_AND:  quick_res = a & b;
            OP_OR:   quick_res = a | b;
            OP_XOR:  quick_res = a ^ b;
            OP_NOT:  quick_res = ~a;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: quick_res = '0;
        endcase
    end

    // Restoring division step: op_a shifts the dividend out and the quotient bits in.
    always_comb begin
        rem_shift = {acc, op_a[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, op_b};
        div_rem   = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        div_quo   = {op_a[WIDTH-2:0], ~rem_diff[WIDTH]};
    end

`ifndef ALU_MUL_FAST_EN
    assign mul_sum = acc + (op_b[0] ? op_a : '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    case (sel)
`ifndef ALU_MUL_FAST_EN
                        OP_MUL:  next_state = MUL;
`endif
                        OP_DIV:  next_state = (b != '0) ? DIV : DONE;
                        default: next_state = DONE;
                    endcase
                end
            end
`ifndef ALU_MUL_FAST_EN
            MUL:     if (last) next_state = DONE;
`endif
            DIV:     if (last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Operand capture, iteration engines and the result registers written on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a        <= '0;
            op_b        <= '0;
            acc         <= '0;
            cnt         <= '0;
            result      <= '0;
            zero        <= 1'b1;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a        <= a;
                        op_b        <= b;
                        acc         <= '0;
                        cnt         <= '0;
                        div_by_zero <= (sel == OP_DIV) && (b == '0);
                        if (next_state == DONE) begin
                            result <= quick_res;
                            zero   <= (quick_res == '0);
                        end
                    end
                end
`ifndef ALU_MUL_FAST_EN
                MUL: begin
                    acc  <= mul_sum;
                    op_a <= op_a << 1;
                    op_b <= op_b >> 1;
                    cnt  <= cnt + CNT_W'(1);
                    if (last) begin
                        result <= mul_sum;
                        zero   <= (mul_sum == '0);
                    end
                end
`endif
                DIV: begin
                    acc  <= div_rem;
                    op_a <= div_quo;
                    cnt  <= cnt + CNT_W'(1);
                    if (last) begin
                        result <= div_quo;
                        zero   <= (div_quo == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: directed vector table, multi-cycle corner
// sequences and randomized ops checked against an arithmetic reference model.
module tb_alu_multiciclo;

    localparam int WIDTH = 32;
    localparam int LONG_LAT = WIDTH + 1;
`ifdef ALU_MUL_FAST_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = LONG_LAT;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             div_by_zero;

    int total;
    int bad;
    int got_lat;
    logic [WIDTH-1:0] got_res;
    logic got_zero;
    logic got_dbz;

    typedef struct {
        string            name;
        logic [3:0]       sel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_res;
        int               exp_lat;
        logic             exp_dbz;
    } vec_t;

    vec_t vecs[9];

    alu_multiciclo #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .sel(sel),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .result(result),
        .zero(zero),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] refResult(input logic [3:0] s, input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        longint unsigned prod;
        case (s)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: begin
                prod = longint'(x) * longint'(y);
                return prod[WIDTH-1:0];
            end
            4'd3: return (y == 0) ? {WIDTH{1'b1}} : x / y;
            4'd4: return x & y;
            4'd5: return x | y;
            4'd6: return x ^ y;
            4'd7: return ~x;
            4'd8: return ($signed(x) < $signed(y)) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int refLatency(input logic [3:0] s, input logic [WIDTH-1:0] y);
        if (s == 4'd2) return MUL_LAT;
        if (s == 4'd3 && y != 0) return LONG_LAT;
        return 1;
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One accepted op; inputs are scrambled after the start edge to prove they were latched.
    task automatic applyStimulus(input logic [3:0] s, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y);
        @(negedge clk);
        sel   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sel   = 4'($urandom);
        got_lat = 1;
        while (!done && got_lat < 200) begin
            @(posedge clk);
            #1;
            got_lat++;
        end
        got_res  = result;
        got_zero = zero;
        got_dbz  = div_by_zero;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]       rs;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH-1:0] er;
        int               dones;

        total = 0;
        bad   = 0;
        start = 1'b0;
        sel   = 4'd0;
        a     = '0;
        b     = '0;

        vecs[0] = '{"add_ovf",  4'd0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1,        1'b0};
        vecs[1] = '{"sub_zero", 4'd1, 32'd5,        32'd5,        32'h0,        1,        1'b0};
        vecs[2] = '{"slt_neg",  4'd8, 32'hFFFFFFFF, 32'h1,        32'h1,        1,        1'b0};
        vecs[3] = '{"slt_swap", 4'd8, 32'h1,        32'hFFFFFFFF, 32'h0,        1,        1'b0};
        vecs[4] = '{"not",      4'd7, 32'h0F0F0F0F, 32'h12345678, 32'hF0F0F0F0, 1,        1'b0};
        vecs[5] = '{"mul",      4'd2, 32'h00012345, 32'h100,      32'h01234500, MUL_LAT,  1'b0};
        vecs[6] = '{"mul_wrap", 4'd2, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, MUL_LAT,  1'b0};
        vecs[7] = '{"div",      4'd3, 32'd100,      32'd7,        32'd14,       LONG_LAT, 1'b0};
        vecs[8] = '{"div0",     4'd3, 32'd9,        32'd0,        32'hFFFFFFFF, 1,        1'b1};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_zero", 32'(zero), 32'd1);
        checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b);
            checkOutput({vecs[i].name, "_lat"}, 32'(got_lat), 32'(vecs[i].exp_lat));
            checkOutput({vecs[i].name, "_res"}, got_res, vecs[i].exp_res);
            checkOutput({vecs[i].name, "_zero"}, 32'(got_zero), 32'(vecs[i].exp_res == 0));
            checkOutput({vecs[i].name, "_dbz"}, 32'(got_dbz), 32'(vecs[i].exp_dbz));
            checkOutput({vecs[i].name, "_idle"}, 32'(busy), 32'd0);
        end

        // A start pulse with new operands during a div must be ignored.
        @(negedge clk);
        sel = 4'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        sel = 4'd0; a = 32'd1; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        got_res = '0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                got_res = result;
            end
        end
        checkOutput("hs_dones", 32'(dones), 32'd1);
        checkOutput("hs_result", got_res, 32'd14);
        checkOutput("hs_dbz", 32'(div_by_zero), 32'd0);

        // Asynchronous reset in the middle of a mul.
        @(negedge clk);
        sel = 4'd2; a = 32'd12345; b = 32'd678; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        checkOutput("mid_rst_result", result, 32'd0);
        checkOutput("mid_rst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'd0, 32'd3, 32'd4);
        checkOutput("post_rst_lat", 32'(got_lat), 32'd1);
        checkOutput("post_rst_res", got_res, 32'd7);

        for (int i = 0; i < 30; i++) begin
            rs = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
            er = refResult(rs, ra, rb);
            applyStimulus(rs, ra, rb);
            checkOutput($sformatf("rnd%0d_lat", i), 32'(got_lat), 32'(refLatency(rs, rb)));
            checkOutput($sformatf("rnd%0d_res", i), got_res, er);
            checkOutput($sformatf("rnd%0d_zero", i), 32'(got_zero), 32'(er == 0));
            checkOutput($sformatf("rnd%0d_dbz", i), 32'(got_dbz), 32'(rs == 4'd3 && rb == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
